// File: rtl/ibex_apb_master.sv
// Bridge from the Ibex data-side req/gnt/rvalid interface to an APB initiator.
// Each granted request becomes one APB transfer (SETUP then ACCESS). The
// response comes back as a one-cycle rvalid pulse. An optional watchdog ends
// an ACCESS phase that the slave never completes, so the core is not stalled.
module ibex_apb_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rstn,
  // core data interface
  input  logic              data_req_i,
  output logic              data_gnt_o,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_rvalid_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_err_o,
  // APB initiator
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [3:0]        pstrb,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // The counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
      CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] wdog_cnt_q;
  logic             wdog_expired;

  // Byte offset is irrelevant: APB is word addressed, sub-word writes use pstrb.
  logic [1:0] unused_addr_lsb;
  assign unused_addr_lsb = data_addr_i[1:0];

  // Grant is the only combinational output: accept whenever idle and out of reset.
  assign data_gnt_o = data_req_i & (state_q == IDLE) & rstn;

  // Watchdog fires on the last permitted ACCESS cycle without pready.
  assign wdog_expired = WDOG_EN && (wdog_cnt_q == CNT_MAX);

  // Transfer sequencer; all APB and response outputs are registered here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      wdog_cnt_q    <= '0;
      psel          <= 1'b0;
      penable       <= 1'b0;
      pwrite        <= 1'b0;
      paddr         <= '0;
      pwdata        <= '0;
      pstrb         <= 4'b0000;
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
      data_err_o    <= 1'b0;
    end else begin
      data_rvalid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_req_i) begin
            paddr   <= {data_addr_i[ADDR_W-1:2], 2'b00};
            pwrite  <= data_we_i;
            pwdata  <= data_wdata_i;
            pstrb   <= data_we_i ? data_be_i : 4'b0000;
            psel    <= 1'b1;
            penable <= 1'b0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          penable    <= 1'b1;
          wdog_cnt_q <= '0;
          state_q    <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            // A completing slave wins over a watchdog expiring in the same cycle.
            data_rdata_o  <= pwrite ? '0 : prdata;
            data_err_o    <= pslverr;
            data_rvalid_o <= 1'b1;
            psel          <= 1'b0;
            penable       <= 1'b0;
            state_q       <= IDLE;
          end else if (wdog_expired) begin
            data_rdata_o  <= '0;
            data_err_o    <= 1'b1;
            data_rvalid_o <= 1'b1;
            psel          <= 1'b0;
            penable       <= 1'b0;
            state_q       <= IDLE;
          end else if (WDOG_EN) begin
            wdog_cnt_q <= wdog_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_apb_master.sv
// Bench for ibex_apb_master: directed table, hand-written multi-cycle
// sequences, and randomized transfers against a transaction-level model.
module tb_ibex_apb_master;

  localparam int T_MAIN  = 8;
  localparam int MAX_CYC = 60;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  logic        gnt, rvalid, err, psel, penable, pwrite;
  logic [31:0] rdata, paddr, pwdata;
  logic [3:0]  pstrb;

  // second instance with the watchdog disabled
  logic        req0 = 1'b0;
  logic        pready0 = 1'b0;
  logic        gnt0, rvalid0, err0, psel0, penable0, pwrite0;
  logic [31:0] rdata0, paddr0, pwdata0;
  logic [3:0]  pstrb0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ibex_apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T_MAIN)) dut (
    .clk(clk), .rstn(rstn),
    .data_req_i(req), .data_gnt_o(gnt), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_err_o(err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  ibex_apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .rstn(rstn),
    .data_req_i(req0), .data_gnt_o(gnt0), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rvalid_o(rvalid0), .data_rdata_o(rdata0), .data_err_o(err0),
    .psel(psel0), .penable(penable0), .pwrite(pwrite0), .paddr(paddr0),
    .pwdata(pwdata0), .pstrb(pstrb0), .prdata(prdata), .pready(pready0),
    .pslverr(pslverr)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        slverr;
    int          waits;      // ACCESS cycles before pready rises
    logic [31:0] exp_paddr;
    logic [3:0]  exp_pstrb;
    int          exp_lat;    // grant-to-rvalid cycles
    logic [31:0] exp_rdata;
    logic        exp_err;
  } txn_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic txn_t mk(input logic w, input logic [3:0] b, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic se,
                              input int ws, input logic [31:0] e_pa, input logic [3:0] e_ps,
                              input int e_lat, input logic [31:0] e_rd, input logic e_err);
    txn_t t;
    t.we = w; t.be = b; t.addr = a; t.wdata = wd; t.prdata = rd; t.slverr = se;
    t.waits = ws; t.exp_paddr = e_pa; t.exp_pstrb = e_ps; t.exp_lat = e_lat;
    t.exp_rdata = e_rd; t.exp_err = e_err;
    return t;
  endfunction

  // Transaction-level reference: a slave answering after 'waits' cycles either
  // completes the transfer, or the watchdog answers first with an error.
  function automatic txn_t model(input txn_t t);
    txn_t r = t;
    r.exp_paddr = t.addr & 32'hFFFF_FFFC;
    r.exp_pstrb = t.we ? t.be : 4'b0000;
    if (t.waits >= T_MAIN) begin
      r.exp_lat   = 2 + T_MAIN;
      r.exp_rdata = 32'h0;
      r.exp_err   = 1'b1;
    end else begin
      r.exp_lat   = 3 + t.waits;
      r.exp_rdata = t.we ? 32'h0 : t.prdata;
      r.exp_err   = t.slverr;
    end
    return r;
  endfunction

  // Issue one request at the current negedge and act as the APB slave.
  task automatic run_txn(input txn_t t, input string tag);
    int  lat;
    bit  seen;
    req = 1'b1; we = t.we; be = t.be; addr = t.addr; wdata = t.wdata;
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    #1;
    chk({tag, "_gnt"}, 64'(gnt), 64'd1);
    @(negedge clk);
    chk({tag, "_nognt_setup"}, 64'(gnt), 64'd0);
    chk({tag, "_setup_sel_en"}, {62'd0, psel, penable}, 64'b10);
    chk({tag, "_paddr"}, 64'(paddr), 64'(t.exp_paddr));
    chk({tag, "_pstrb"}, 64'(pstrb), 64'(t.exp_pstrb));
    chk({tag, "_pwrite"}, 64'(pwrite), 64'(t.we));
    chk({tag, "_pwdata"}, 64'(pwdata), 64'(t.wdata));
    req = 1'b0; addr = $urandom; wdata = $urandom; we = $urandom; be = $urandom;
    seen = 1'b0; lat = 0;
    for (int c = 2; c < MAX_CYC; c++) begin
      @(negedge clk);
      if (rvalid) begin
        seen = 1'b1; lat = c;
        break;
      end
      chk({tag, "_access"}, {psel, penable, paddr, pstrb}, {1'b1, 1'b1, t.exp_paddr, t.exp_pstrb});
      pready  = (c - 2 == t.waits);
      pslverr = pready ? t.slverr : 1'($urandom);
      prdata  = pready ? t.prdata : $urandom;
    end
    pready = 1'b0;
    chk({tag, "_rvalid_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(t.exp_lat));
    chk({tag, "_rdata"}, 64'(rdata), 64'(t.exp_rdata));
    chk({tag, "_err"}, 64'(err), 64'(t.exp_err));
    chk({tag, "_psel_low"}, {62'd0, psel, penable}, 64'd0);
    @(negedge clk);
    chk({tag, "_rvalid_pulse"}, 64'(rvalid), 64'd0);
    chk({tag, "_rdata_hold"}, {31'd0, err, rdata}, {31'd0, t.exp_err, t.exp_rdata});
  endtask

  initial begin
    txn_t tbl[7];
    txn_t t;
    logic [10:0] gnt_mask, rv_mask;
    bit any_rv, psel_drop;

    tbl[0] = mk(1'b1, 4'b1100, 32'h1000_0006, 32'hDEAD_BEEF, 32'h0, 1'b0, 0,
                32'h1000_0004, 4'b1100, 3, 32'h0, 1'b0);
    tbl[1] = mk(1'b0, 4'b1111, 32'h1000_0010, 32'h5555_5555, 32'h1234_5678, 1'b0, 2,
                32'h1000_0010, 4'b0000, 5, 32'h1234_5678, 1'b0);
    tbl[2] = mk(1'b0, 4'b1111, 32'h4000_0003, 32'h0, 32'hCAFE_F00D, 1'b1, 1,
                32'h4000_0000, 4'b0000, 4, 32'hCAFE_F00D, 1'b1);
    tbl[3] = mk(1'b1, 4'b0011, 32'h4000_0001, 32'h0000_ABCD, 32'hFFFF_FFFF, 1'b0, 0,
                32'h4000_0000, 4'b0011, 3, 32'h0, 1'b0);
    tbl[4] = mk(1'b0, 4'b1111, 32'h5000_0008, 32'h0, 32'h7777_7777, 1'b0, 100,
                32'h5000_0008, 4'b0000, 10, 32'h0, 1'b1);
    tbl[5] = mk(1'b0, 4'b0001, 32'h6000_000C, 32'h0, 32'h0BAD_C0DE, 1'b0, 7,
                32'h6000_000C, 4'b0000, 10, 32'h0BAD_C0DE, 1'b0);
    tbl[6] = mk(1'b1, 4'b0101, 32'h7000_000F, 32'h1122_3344, 32'h9999_9999, 1'b1, 3,
                32'h7000_000C, 4'b0101, 6, 32'h0, 1'b1);

    // reset state
    #2;
    chk("rst_apb", {psel, penable, pwrite, pstrb, paddr}, 64'd0);
    chk("rst_resp", {rvalid, err, rdata}, 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i], $sformatf("tbl%0d", i));
      $display("tbl%0d done: we=%0b paddr=%h lat=%0d rdata=%h err=%0b",
               i, tbl[i].we, tbl[i].exp_paddr, tbl[i].exp_lat, tbl[i].exp_rdata, tbl[i].exp_err);
    end

    // back-to-back writes with req held and pready tied high
    gnt_mask = '0; rv_mask = '0;
    pready = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h8000_0000; wdata = 32'h1;
    req = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k == 7) req = 1'b0;
      #1;
      gnt_mask[k] = gnt;
      rv_mask[k]  = rvalid;
      @(negedge clk);
    end
    pready = 1'b0; req = 1'b0;
    chk("b2b_grants", 64'(gnt_mask), 64'b000_0100_1001);
    chk("b2b_rvalids", 64'(rv_mask), 64'b010_0100_1000);
    $display("b2b done: gnt_mask=%b rv_mask=%b", gnt_mask, rv_mask);

    // asynchronous reset in the middle of a wait state
    req = 1'b1; we = 1'b0; addr = 32'h0000_0020; pready = 1'b0;
    @(negedge clk); req = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_sel_en_rv", {61'd0, psel, penable, rvalid}, 64'd0);
    chk("mid_rst_paddr", 64'(paddr), 64'd0);
    @(negedge clk); rstn = 1'b1;
    any_rv = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rvalid || psel) any_rv = 1'b1;
    end
    chk("mid_rst_no_resp", 64'(any_rv), 64'd0);
    $display("mid-access reset done");
    run_txn(tbl[1], "post_rst");

    // randomized transfers against the model
    for (int i = 0; i < 40; i++) begin
      t.we = 1'($urandom); t.be = 4'($urandom); t.addr = $urandom; t.wdata = $urandom;
      t.prdata = $urandom; t.slverr = ($urandom_range(0, 3) == 0);
      t.waits = $urandom_range(0, 11);
      t = model(t);
      run_txn(t, $sformatf("rnd%0d", i));
      $display("rnd%0d done: we=%0b addr=%h waits=%0d lat=%0d err=%0b",
               i, t.we, t.addr, t.waits, t.exp_lat, t.exp_err);
    end

    // watchdog disabled: a silent slave holds the bus indefinitely
    req0 = 1'b1; pready0 = 1'b0;
    #1;
    chk("t0_gnt", 64'(gnt0), 64'd1);
    @(negedge clk); req0 = 1'b0;
    any_rv = 1'b0; psel_drop = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (rvalid0) any_rv = 1'b1;
      if (!psel0) psel_drop = 1'b1;
    end
    chk("t0_no_rvalid", 64'(any_rv), 64'd0);
    chk("t0_psel_held", 64'(psel_drop), 64'd0);
    $display("no-watchdog hang done: rvalid_seen=%0b psel_dropped=%0b", any_rv, psel_drop);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
